// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl
// Drives one dual-copy boolean network through a Floyd cycle search.
// The hare copy (s1) advances on every step. The tortoise copy (s0) advances
// on every other step, using the node-internal pass bit. Once the two copies
// meet, the tortoise is frozen and the hare walks the cycle once to measure
// the attractor period. The result is offered on a valid/ready port.
module gnr_attractor_ctrl #(
  parameter int NODES     = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [NODES-1:0] init_in,
  input  logic [NODES-1:0] s0_vec,
  input  logic [NODES-1:0] s1_vec,
  output logic             reset_nos,
  output logic [NODES-1:0] init_state,
  output logic             start_s0,
  output logic             start_s1,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             found,
  output logic [CNT_W-1:0] meet_steps,
  output logic [CNT_W-1:0] period
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    SEARCH = 3'd2,
    PERIOD = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] period_cnt;

  // Event flags, already qualified by state and abort
  logic             vec_eq;
  logic             match;
  logic             pmatch;
  logic             search_meet;
  logic             search_tout;
  logic             period_hit;
  logic             period_tout;
  logic             run_accept;

  // The node outputs are registered, so they can be compared directly.
  // At step 0 both copies hold init_state. At step 1 both have taken the
  // same first step. Equality below two steps therefore says nothing.
  always_comb begin
    vec_eq      = (s0_vec == s1_vec);
    match       = vec_eq && (step_cnt >= TWO);
    pmatch      = vec_eq && (period_cnt >= ONE);
    run_accept  = (state == IDLE) && start;
    search_meet = (state == SEARCH) && !abort && match;
    search_tout = (state == SEARCH) && !abort && !match && (step_cnt == MAX_CNT);
    period_hit  = (state == PERIOD) && !abort && pmatch;
    period_tout = (state == PERIOD) && !abort && !pmatch && (period_cnt == MAX_CNT);
  end

  // Next-state and step strobes: a step goes out only when no event or abort
  // ends the phase in the same cycle.
  always_comb begin
    state_nxt = state;
    reset_nos = 1'b0;
    start_s0  = 1'b0;
    start_s1  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = INIT;
      end
      INIT: begin
        reset_nos = 1'b1;
        state_nxt = abort ? IDLE : SEARCH;
      end
      SEARCH: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (match) begin
          state_nxt = PERIOD;
        end else if (step_cnt == MAX_CNT) begin
          state_nxt = DONE;
        end else begin
          start_s0 = 1'b1;
          start_s1 = 1'b1;
        end
      end
      PERIOD: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (pmatch || (period_cnt == MAX_CNT)) begin
          state_nxt = DONE;
        end else begin
          start_s1 = 1'b1;
        end
      end
      DONE: begin
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs follow the state directly
  always_comb begin
    busy      = (state != IDLE);
    res_valid = (state == DONE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Step and period counters: cleared on run accept, advanced per hare step
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt   <= '0;
      period_cnt <= '0;
    end else if (run_accept) begin
      step_cnt   <= '0;
      period_cnt <= '0;
    end else if (start_s1) begin
      if (state == SEARCH) step_cnt   <= step_cnt + ONE;
      else                 period_cnt <= period_cnt + ONE;
    end
  end

  // Latched init vector and result fields; these stay stable through DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      init_state <= '0;
      meet_steps <= '0;
      period     <= '0;
      found      <= 1'b0;
    end else begin
      if (run_accept) init_state <= init_in;
      if (search_meet || search_tout) meet_steps <= step_cnt;
      if (search_tout || period_tout) begin
        found  <= 1'b0;
        period <= '0;
      end else if (period_hit) begin
        found  <= 1'b1;
        period <= period_cnt;
      end
    end
  end

endmodule
